// File: rtl/dff_ctrl_pkg.sv
// Shared types and helpers for the shared D-register arbiter.
package dff_ctrl_pkg;

  // Arbiter FSM: IDLE picks a winner, GRANT commits or aborts it.
  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // Index width for n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_picker.sv
// Combinational round-robin picker: scans from pointer+1 upward (mod
// NUM_REQ) and reports the first asserted request.
module rr_picker
  import dff_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               found,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  logic [IDX_W-1:0] cand;

  // Search the rotated request vector; the pointer itself is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(pointer) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot[i] = found && (winner == IDX_W'(i));
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin owner of a single shared WIDTH-bit register. A requester is
// granted in one cycle and its lane is committed in the next, provided it
// still holds req; otherwise the grant is silently dropped.
module dff_share_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [IDX_W-1:0]   pointer;
  logic [IDX_W-1:0]   pointer_nxt;
  logic [IDX_W-1:0]   winner_q;
  logic [IDX_W-1:0]   winner_nxt;
  logic [IDX_W-1:0]   owner_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               q_valid_nxt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_winner;
  logic [NUM_REQ-1:0] pick_onehot;

  logic [WIDTH-1:0]   lanes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lanes[i] = wdata[i*WIDTH +: WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .pointer (pointer),
    .found   (pick_found),
    .winner  (pick_winner),
    .onehot  (pick_onehot)
  );

  // Register bank: everything the arbiter remembers, cleared asynchronously.
  // The pointer starts at the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      ack      <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      owner    <= '0;
      pointer  <= IDX_W'(NUM_REQ - 1);
      winner_q <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      ack      <= ack_nxt;
      q        <= q_nxt;
      q_valid  <= q_valid_nxt;
      owner    <= owner_nxt;
      pointer  <= pointer_nxt;
      winner_q <= winner_nxt;
    end
  end

  // Next-state logic: grant from IDLE only when enabled, then commit or
  // abort unconditionally in GRANT (en is deliberately ignored there).
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = '0;
    ack_nxt     = '0;
    q_nxt       = q;
    q_valid_nxt = q_valid;
    owner_nxt   = owner;
    pointer_nxt = pointer;
    winner_nxt  = winner_q;
    case (state)
      IDLE: begin
        if (en && pick_found) begin
          gnt_nxt    = pick_onehot;
          winner_nxt = pick_winner;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (req[winner_q]) begin
          q_nxt       = lanes[winner_q];
          ack_nxt     = gnt;
          owner_nxt   = winner_q;
          q_valid_nxt = 1'b1;
          pointer_nxt = winner_q;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  gnt_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  ack_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  ack_after_gnt_a: assert property (@(posedge clk) disable iff (!rst_n)
    (|ack) |-> (ack == $past(gnt)));

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios plus a
// randomized phase, all scored against a behavioural model.
module tb_dff_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IW      = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     en;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic [IW-1:0]            owner;

  logic [WIDTH-1:0]         lane_tb [NUM_REQ];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] data;
  } commit_t;

  commit_t exp_q[$];

  // Behavioural model state
  logic               m_busy;
  logic [IW-1:0]      m_win;
  logic [IW-1:0]      m_ptr;
  logic [NUM_REQ-1:0] m_gnt;
  logic [NUM_REQ-1:0] m_ack;
  logic [WIDTH-1:0]   m_q;
  logic [IW-1:0]      m_cand;
  logic               m_hit;

  bit rand_phase = 1'b0;
  int wait_cnt [NUM_REQ];

  dff_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  // Pack the per-requester lanes into the flat wdata bus.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) wdata[i*WIDTH +: WIDTH] = lane_tb[i];
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] r, input logic e);
    req = r;
    en  = e;
  endtask

  task automatic set_lane(input logic [IW-1:0] i, input logic [WIDTH-1:0] d);
    lane_tb[i] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a requester granted at one edge commits at the next if
  // still requesting; winners are chosen by rotating priority after the last
  // committed requester. Each predicted commit is pushed to the scoreboard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_win  = '0;
      m_ptr  = IW'(NUM_REQ - 1);
      m_gnt  = '0;
      m_ack  = '0;
      m_q    = '0;
      exp_q.delete();
    end else begin
      m_ack = '0;
      if (m_busy) begin
        if (req[m_win]) begin
          m_q          = lane_tb[m_win];
          m_ptr        = m_win;
          m_ack[m_win] = 1'b1;
          exp_q.push_back('{idx: m_win, data: lane_tb[m_win]});
        end
        m_busy = 1'b0;
        m_gnt  = '0;
      end else if (en && (req != '0)) begin
        m_hit = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_cand = IW'((int'(m_ptr) + k) % NUM_REQ);
          if (!m_hit && req[m_cand]) begin
            m_hit = 1'b1;
            m_win = m_cand;
          end
        end
        m_busy = 1'b1;
        m_gnt  = NUM_REQ'(1) << m_win;
      end else begin
        m_gnt = '0;
      end
    end
  end

  // Monitor: compares DUT outputs with the model every cycle and pops the
  // scoreboard whenever an ack appears.
  always @(posedge clk) begin
    commit_t c;
    #1;
    if (rst_n) begin
      check_output("gnt_vs_model", 32'(gnt), 32'(m_gnt));
      check_output("ack_vs_model", 32'(ack), 32'(m_ack));
      check_output("q_vs_model", 32'(q), 32'(m_q));
      check_output("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check_output("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          c = exp_q.pop_front();
          check_output("sb_ack", 32'(ack), 32'(NUM_REQ'(1) << c.idx));
          check_output("sb_q", 32'(q), 32'(c.data));
          check_output("sb_owner", 32'(owner), 32'(c.idx));
          check_output("sb_q_valid", 32'(q_valid), 32'd1);
        end
      end else if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        check_output("missing_ack", 32'(ack), 32'(NUM_REQ'(1) << c.idx));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rand_phase) begin
          wait_cnt[i] = 0;
        end else if (ack[IW'(i)]) begin
          check_output("starvation_bound", 32'(wait_cnt[i] <= 2 * NUM_REQ), 32'd1);
          wait_cnt[i] = 0;
        end else if (req[IW'(i)]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d tests run, expected completion", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by the randomized phase.
  initial begin
    int exp_order [5];
    logic [WIDTH-1:0] exp_data [5];
    int order[$];
    logic [WIDTH-1:0] qs[$];
    int ack_cyc[$];
    logic [NUM_REQ-1:0] drop;

    exp_order = '{0, 1, 2, 3, 0};
    exp_data  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

    rst_n = 1'b0;
    apply_stimulus('0, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) lane_tb[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_gnt", 32'(gnt), 32'd0);
    check_output("reset_ack", 32'(ack), 32'd0);
    check_output("reset_q", 32'(q), 32'd0);
    check_output("reset_q_valid", 32'(q_valid), 32'd0);
    check_output("reset_owner", 32'(owner), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single requester on lane 2
    @(negedge clk);
    set_lane(2'd2, 8'hA5);
    apply_stimulus(4'b0100, 1'b1);
    tick();
    check_output("single_gnt", 32'(gnt), 32'h4);
    tick();
    check_output("single_q", 32'(q), 32'hA5);
    check_output("single_ack", 32'(ack), 32'h4);
    check_output("single_owner", 32'(owner), 32'd2);
    check_output("single_q_valid", 32'(q_valid), 32'd1);
    @(negedge clk) apply_stimulus('0, 1'b1);
    tick();
    check_output("single_ack_pulse", 32'(ack), 32'd0);

    // All four requesting, fresh priority after a reset
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_lane(2'd0, 8'h10);
    set_lane(2'd1, 8'h21);
    set_lane(2'd2, 8'h32);
    set_lane(2'd3, 8'h43);
    apply_stimulus(4'b1111, 1'b1);
    drop = '0;
    for (int cyc = 0; cyc < 40 && order.size() < 5; cyc++) begin
      @(negedge clk);
      req  = req | drop;
      drop = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[IW'(i)]) begin
          order.push_back(i);
          qs.push_back(q);
          ack_cyc.push_back(cyc);
          req[IW'(i)]  = 1'b0;
          drop[IW'(i)] = 1'b1;
        end
      end
    end
    check_output("rr_commit_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size(); k++) begin
      check_output("rr_order", 32'(order[k]), 32'(exp_order[k]));
      check_output("rr_q", 32'(qs[k]), 32'(exp_data[k]));
      if (k > 0) check_output("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd2);
    end
    @(negedge clk) apply_stimulus('0, 1'b1);
    repeat (2) @(negedge clk);

    // Abort: requester 1 drops req while granted
    set_lane(2'd1, 8'h77);
    apply_stimulus(4'b0010, 1'b1);
    tick();
    check_output("abort_gnt", 32'(gnt), 32'h2);
    @(negedge clk) apply_stimulus('0, 1'b1);
    tick();
    check_output("abort_ack", 32'(ack), 32'd0);
    check_output("abort_q", 32'(q), 32'h10);
    check_output("abort_owner", 32'(owner), 32'd0);
    @(negedge clk);
    set_lane(2'd3, 8'h99);
    apply_stimulus(4'b1000, 1'b1);
    tick();
    check_output("after_abort_gnt", 32'(gnt), 32'h8);
    tick();
    check_output("after_abort_ack", 32'(ack), 32'h8);
    check_output("after_abort_q", 32'(q), 32'h99);
    check_output("after_abort_owner", 32'(owner), 32'd3);
    @(negedge clk) apply_stimulus('0, 1'b1);

    // en low blocks grants; dropping en during GRANT still commits
    @(negedge clk);
    set_lane(2'd0, 8'hC0);
    set_lane(2'd1, 8'hC1);
    set_lane(2'd2, 8'hC2);
    set_lane(2'd3, 8'hC3);
    apply_stimulus(4'b1111, 1'b0);
    repeat (10) begin
      tick();
      check_output("en_low_gnt", 32'(gnt), 32'd0);
    end
    @(negedge clk) en = 1'b1;
    tick();
    check_output("en_high_gnt", 32'(gnt), 32'h1);
    @(negedge clk) en = 1'b0;
    tick();
    check_output("en_drop_ack", 32'(ack), 32'h1);
    check_output("en_drop_q", 32'(q), 32'hC0);
    tick();
    check_output("en_drop_no_regrant", 32'(gnt), 32'd0);
    @(negedge clk) apply_stimulus('0, 1'b1);

    // Reset in the middle of a GRANT cycle
    @(negedge clk);
    set_lane(2'd2, 8'h5A);
    apply_stimulus(4'b0100, 1'b1);
    tick();
    check_output("midreset_gnt_before", 32'(gnt), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check_output("midreset_gnt", 32'(gnt), 32'd0);
    check_output("midreset_ack", 32'(ack), 32'd0);
    check_output("midreset_q", 32'(q), 32'd0);
    check_output("midreset_q_valid", 32'(q_valid), 32'd0);
    set_lane(2'd0, 8'h3C);
    apply_stimulus(4'b0101, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_output("postreset_gnt", 32'(gnt), 32'h1);
    tick();
    check_output("postreset_ack", 32'(ack), 32'h1);
    check_output("postreset_q", 32'(q), 32'h3C);
    @(negedge clk) apply_stimulus('0, 1'b1);
    repeat (3) @(negedge clk);

    // Randomized traffic obeying the hold-until-ack contract
    rand_phase = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[IW'(i)]) begin
          if ($urandom_range(1, 0) == 1) begin
            req[IW'(i)] = 1'b1;
            set_lane(IW'(i), WIDTH'($urandom));
          end else begin
            req[IW'(i)] = 1'b0;
          end
        end else if (!req[IW'(i)] && ($urandom_range(2, 0) == 0)) begin
          req[IW'(i)] = 1'b1;
          set_lane(IW'(i), WIDTH'($urandom));
        end
      end
    end
    @(negedge clk);
    rand_phase = 1'b0;
    apply_stimulus('0, 1'b1);
    repeat (4) @(negedge clk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
